// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the EX-stage combinational array multiplier.
// It registers the operands and holds mul_en through a settle window, then
// captures the signed product and corrects the high word for the unsigned
// forms. A one-entry product cache lets a MULH/MUL pair on the same operands
// finish in a single cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; a cache hit jumps straight to DONE
// SETTLE  | multiplier enabled, counting the settle window, waiting mul_done
// CORRECT | capture product into the cache, form the corrected word
// DONE    | result_valid strobe for one cycle, then back to IDLE
module mul_seq_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    start,
  input  logic [1:0]              funct,
  input  logic [DATA_WIDTH-1:0]   op1,
  input  logic [DATA_WIDTH-1:0]   op2,
  output logic                    stall_req,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    mul_en,
  output logic [DATA_WIDTH-1:0]   mul_op1,
  output logic [DATA_WIDTH-1:0]   mul_op2,
  input  logic                    mul_done,
  input  logic [2*DATA_WIDTH-1:0] mul_result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The counter saturates here, so a late mul_done just holds the count.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              counter;
  logic [1:0]              funct_q;
  logic [2*DATA_WIDTH-1:0] cache_p;
  logic [DATA_WIDTH-1:0]   cache_a;
  logic [DATA_WIDTH-1:0]   cache_b;
  logic                    cache_valid;
  logic                    cache_hit;

  // The multiplier always forms the signed x signed product. The unsigned
  // high words are recovered by adding back whichever operand was treated
  // as negative; the result wraps modulo 2^DATA_WIDTH and carries are dropped.
  function automatic logic [DATA_WIDTH-1:0] sel_word(
    input logic [1:0]              f,
    input logic [2*DATA_WIDTH-1:0] p,
    input logic [DATA_WIDTH-1:0]   a,
    input logic [DATA_WIDTH-1:0]   b
  );
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    hi    = p[2*DATA_WIDTH-1:DATA_WIDTH];
    add_a = b[DATA_WIDTH-1] ? a : '0;
    add_b = a[DATA_WIDTH-1] ? b : '0;
    case (f)
      2'b10:   hi = hi + add_a;
      2'b11:   hi = hi + add_a + add_b;
      default: hi = hi;
    endcase
    return (f == 2'b00) ? p[DATA_WIDTH-1:0] : hi;
  endfunction

  assign cache_hit    = cache_valid && (op1 == cache_a) && (op2 == cache_b);
  assign result_valid = (state == DONE);

  // Next-state decode plus the stall and multiplier-enable outputs.
  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    mul_en    = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start;
        if (start) begin
          state_nxt = cache_hit ? DONE : SETTLE;
        end
      end
      SETTLE: begin
        mul_en    = 1'b1;
        stall_req = 1'b1;
        if ((counter == CNT_LAST) && mul_done) begin
          state_nxt = CORRECT;
        end
      end
      CORRECT: begin
        mul_en    = 1'b1;
        stall_req = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, settle counter, product cache and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      funct_q     <= '0;
      mul_op1     <= '0;
      mul_op2     <= '0;
      result      <= '0;
      cache_p     <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (cache_hit) begin
              result <= sel_word(funct, cache_p, op1, op2);
            end else begin
              mul_op1 <= op1;
              mul_op2 <= op2;
              funct_q <= funct;
              counter <= '0;
            end
          end
        end
        SETTLE: begin
          if (counter != CNT_LAST) begin
            counter <= counter + 4'd1;
          end
        end
        CORRECT: begin
          // The product is already correct here, so the cache is filled
          // even if this operation is being flushed.
          cache_p     <= mul_result;
          cache_a     <= mul_op1;
          cache_b     <= mul_op2;
          cache_valid <= 1'b1;
          if (!flush) begin
            result <= sel_word(funct_q, mul_result, mul_op1, mul_op2);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural signed multiplier
// whose done indication can be delayed past the settle window.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] result;
  logic        mul_en;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic        mul_done;
  logic [63:0] mul_result;

  mul_seq_ctrl #(.DATA_WIDTH(32), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .start        (start),
    .funct        (funct),
    .op1          (op1),
    .op2          (op2),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result),
    .mul_en       (mul_en),
    .mul_op1      (mul_op1),
    .mul_op2      (mul_op2),
    .mul_done     (mul_done),
    .mul_result   (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   en_total = 0;
  int   done_at = 0;
  logic prev_valid = 1'b0;

  // Multiplier model: signed x signed product, done after done_at enabled cycles.
  assign mul_result = $signed({{32{mul_op1[31]}}, mul_op1}) * $signed({{32{mul_op2[31]}}, mul_op2});
  assign mul_done   = (en_cnt >= done_at);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    en_cnt   <= mul_en ? en_cnt + 1 : 0;
    en_total <= en_total + (mul_en ? 1 : 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result strobe.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      exp_t e;
      check("valid_gap", prev_valid, 0);
      check("stall_in_done", stall_req, 0);
      check("mul_en_in_done", mul_en, 0);
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("latency", cyc - e.issue, e.lat);
      end
    end
    prev_valid <= result_valid;
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    funct = f;
    op1   = a;
    op2   = b;
    e.res   = exp_res;
    e.lat   = lat;
    e.issue = cyc;
    q.push_back(e);
    #1;
    check("stall_on_issue", stall_req, 1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  // Starts an operation and flushes it k cycles after the start cycle.
  task automatic issue_flush(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                             input int k);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    op1   = a;
    op2   = b;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_mul_en", mul_en, 0);
    check("flush_stall", stall_req, 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int t0;
    rst   = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    funct = 2'b00;
    op1   = '0;
    op2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", result_valid, 0);
    check("rst_stall", stall_req, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_result", result, 0);
    check("rst_ops", {mul_op1, mul_op2}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid", result_valid, 0);
    check("idle_stall", stall_req, 0);
    check("idle_mul_en_total", en_total, 0);

    // MUL miss: 7 * -3
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 6);
    // MULH miss: 2^62, then MUL hit on the same operands
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6);
    t0 = en_total;
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1);
    check("hit_no_mul_en", en_total - t0, 0);
    // MULHU miss, then MULHSU hit using the cached product
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    // Unsigned corrections with a single negative-looking operand
    issue(2'b11, 32'h8000_0000, 32'd2, 32'h0000_0001, 6);
    issue(2'b10, 32'd2, 32'h8000_0000, 32'h0000_0001, 6);
    // Late mul_done: three extra SETTLE cycles, -2 * 3 high word
    done_at = 6;
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 9);
    done_at = 0;
    // Flush in CORRECT still fills the cache: MUL on the same operands hits
    issue_flush(2'b01, 32'd9, 32'd10, 5);
    issue(2'b00, 32'd9, 32'd10, 32'd90, 1);
    // Flush in the 2nd SETTLE cycle leaves the cache alone
    issue_flush(2'b00, 32'd5, 32'd6, 2);
    issue(2'b01, 32'd9, 32'd10, 32'd0, 1);
    issue(2'b00, 32'd5, 32'd6, 32'd30, 6);
    // Flush and start together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op1   = 32'd11;
    op2   = 32'd12;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_mul_en", mul_en, 0);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle controller that sequences the EX-stage combinational array multiplier.
- Registers the operands and holds the multiplier enabled for a fixed settle window. Captures the 64-bit signed product and applies the unsigned high-word correction for the RV32M MUL/MULH/MULHSU/MULHU variants.
- Stalls the pipeline while busy and returns one 32-bit result with a one-cycle valid strobe.
- Keeps a one-entry product cache, so a MULH/MUL pair on identical operands completes in one cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; product is 2*DATA_WIDTH.
- SETTLE_CYCLES, 4, cycles mul_en is held before the product may be captured; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- start  input  1  issue request from EX; sampled only in IDLE.
- funct  input  2  00 MUL (low word), 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u).
- op1  input  DATA_WIDTH  rs1 value.
- op2  input  DATA_WIDTH  rs2 value.
- stall_req  output  1  hold the pipeline while an operation is pending.
- result_valid  output  1  one-cycle strobe, result is valid.
- result  output  DATA_WIDTH  selected/corrected word.
- mul_en  output  1  enable to the multiplier.
- mul_op1  output  DATA_WIDTH  registered operand A to the multiplier.
- mul_op2  output  DATA_WIDTH  registered operand B to the multiplier.
- mul_done  input  1  multiplier carry-chain done indication.
- mul_result  input  2*DATA_WIDTH  signed 64-bit product from the multiplier.

Behaviour:
- Reset values: state=IDLE, stall_req=0, result_valid=0, result=0, mul_en=0, mul_op1=mul_op2=0, counter=0, cache_valid=0. Reset overrides flush and start.
- States: IDLE, SETTLE, CORRECT, DONE.
- IDLE:
  - stall_req = start (combinational), so the issuing cycle stalls.
  - On start with cache_valid and {op1,op2} equal to the cached operands: go to DONE. No multiplier activity. Latency 1.
  - Otherwise latch op1/op2/funct into mul_op1/mul_op2/funct_q, clear the counter, and go to SETTLE.
- SETTLE:
  - mul_en=1, stall_req=1, counter increments each cycle.
  - Go to CORRECT when counter==SETTLE_CYCLES-1 and mul_done=1.
  - If the count is reached with mul_done=0, hold in SETTLE (counter saturates) until mul_done=1.
- CORRECT:
  - mul_en=1, stall_req=1.
  - Register P=mul_result, cache P and operands, set cache_valid=1.
  - Compute hi:
    - MULH: hi = P[63:32].
    - MULHSU: hi = P[63:32] + (B[31]?A:0).
    - MULHU: hi = P[63:32] + (A[31]?B:0) + (B[31]?A:0).
    - All sums are mod 2^32; carries discarded.
  - Low word is P[31:0] for MUL in every variant.
  - Go to DONE.
- DONE:
  - result_valid=1, result = selected word per funct_q (or per the current funct on a cache hit, using the cached P).
  - stall_req=0, mul_en=0. Return to IDLE next cycle.
  - A start in DONE is ignored; EX reissues only after the pipeline advances.
- Latency from the start cycle to result_valid: SETTLE_CYCLES+2 on a miss (minimum), 1 on a hit.
- result holds its last value until the next DONE. result_valid never asserts in two consecutive cycles.
- flush in any state:
  - Next state is IDLE; mul_en and stall_req drop next cycle.
  - No result_valid for the aborted operation.
  - A flush in CORRECT still updates the cache (the product is correct); a flush in SETTLE leaves the cache unchanged.
- Simultaneous flush and start in IDLE: flush wins, no operation starts.
- Operand 0x80000000 is legal; the product magnitude of 2^62 is handled by the multiplier without overflow.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then start=0 → all outputs 0, state IDLE, mul_en never asserts.
- MUL miss: funct=00, op1=7, op2=0xFFFFFFFD, SETTLE_CYCLES=4 → stall_req high for 6 cycles, result_valid on cycle 6, result=0xFFFFFFEB.
- MULH: op1=op2=0x80000000 → result=0x40000000. Then reissue funct=00 with the same operands → result_valid on the next cycle, result=0x00000000, mul_en stays 0.
- MULHU / MULHSU correction:
  - MULHU with op1=op2=0xFFFFFFFF → result=0xFFFFFFFE.
  - MULHSU with op1=0xFFFFFFFF, op2=0xFFFFFFFF → result=0xFFFFFFFF.
- Late mul_done: hold mul_done=0 for 3 extra cycles past the settle count → controller stays in SETTLE, result_valid is delayed by 3, value is correct.
- Flush: assert flush on the 2nd SETTLE cycle → IDLE next cycle, no result_valid, cache_valid unchanged. A following start with the same operands misses and runs the full latency.
